// File: rtl/kbd_cmd_scheduler.sv
// kbd_cmd_scheduler
//   Decodes a PS/2 Set-2 scancode stream into display commands, queues them
//   in a small FIFO and releases at most one command per video frame, on the
//   falling edge of vsync, so downstream blocks only change between frames.
//
// Ports
//   clk         pixel clock, rising edge
//   reset       synchronous, active-high
//   flag        one-cycle strobe, scancode valid
//   scancode    received PS/2 byte
//   vsync       VGA vertical sync, active low
//   cmd_valid   one-cycle pulse, cmd valid
//   cmd         0 none, 1 up, 2 down, 3 left, 4 right, 5 colour, 6 char, 7 blink
//   fifo_count  queued commands (0..DEPTH)
//   overflow    sticky, a command was dropped on a full FIFO
//
// Build option
//   REPEAT_SUPPRESS_EN  suppress typematic repeat with a held-key register
module kbd_cmd_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flag,
    input  logic [7:0] scancode,
    input  logic       vsync,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic [4:0] fifo_count,
    output logic       overflow
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t state, state_nxt;

    logic          make_ev;
    logic          ev_ext;
    logic [2:0]    map_cmd;
    logic          suppressed;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          vsync_q;
    logic          vs_fall;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [2:0]    mem [DEPTH];

    // ------------------------------------------------------------------
    // Decoder FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        make_ev   = 1'b0;
        if (flag) begin
            case (state)
                IDLE: begin
                    if (scancode == 8'hE0)      state_nxt = EXT;
                    else if (scancode == 8'hF0) state_nxt = BRK;
                    else                        make_ev   = 1'b1;
                end
                EXT: begin
                    if (scancode == 8'hF0) state_nxt = EXT_BRK;
                    else begin
                        make_ev   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK:     state_nxt = IDLE;
                EXT_BRK: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign ev_ext = (state == EXT) || (state == EXT_BRK);

    // Key map; 0 means unmapped
    always_comb begin
        map_cmd = 3'd0;
        if (ev_ext) begin
            case (scancode)
                8'h75:   map_cmd = 3'd1;
                8'h72:   map_cmd = 3'd2;
                8'h6B:   map_cmd = 3'd3;
                8'h74:   map_cmd = 3'd4;
                default: map_cmd = 3'd0;
            endcase
        end else begin
            case (scancode)
                8'h1D:   map_cmd = 3'd1;
                8'h1B:   map_cmd = 3'd2;
                8'h1C:   map_cmd = 3'd3;
                8'h23:   map_cmd = 3'd4;
                8'h21:   map_cmd = 3'd5;
                8'h22:   map_cmd = 3'd6;
                8'h32:   map_cmd = 3'd7;
                default: map_cmd = 3'd0;
            endcase
        end
    end

`ifdef REPEAT_SUPPRESS_EN
    logic [8:0] held_key;
    logic [8:0] ev_key;
    logic       brk_ev;

    assign ev_key     = {ev_ext, scancode};
    assign brk_ev     = flag && ((state == BRK) || (state == EXT_BRK));
    assign suppressed = (ev_key == held_key);

    // Cleared value {0,00} never matches a mapped key
    always_ff @(posedge clk) begin
        if (reset)                             held_key <= '0;
        else if (push)                         held_key <= ev_key;
        else if (brk_ev && ev_key == held_key) held_key <= '0;
    end
`else
    assign suppressed = 1'b0;
`endif

    assign push = make_ev && (map_cmd != 3'd0) && !suppressed;

    // ------------------------------------------------------------------
    // Frame scheduler and FIFO
    // ------------------------------------------------------------------
    assign vs_fall = vsync_q && !vsync;
    assign full    = (fifo_count == 5'(DEPTH));
    assign pop     = vs_fall && (fifo_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= map_cmd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q    <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd        <= '0;
        end else begin
            vsync_q   <= vsync;
            cmd_valid <= pop;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                cmd    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_kbd_cmd_scheduler.sv
// Directed testbench for kbd_cmd_scheduler (DEPTH=4).
module tb_kbd_cmd_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flag = 1'b0;
    logic [7:0] scancode = '0;
    logic       vsync = 1'b1;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [4:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    kbd_cmd_scheduler #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .flag       (flag),
        .scancode   (scancode),
        .vsync      (vsync),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        flag     = 1'b1;
        scancode = b;
        @(negedge clk);
        flag     = 1'b0;
    endtask

    // Key press followed by its release
    task automatic tap(input logic [7:0] b);
        send_byte(b);
        send_byte(8'hF0);
        send_byte(b);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One vsync low frame; checks the pulse seen one cycle after vsync reads 0
    task automatic frame(input string tag, input logic exp_valid, input logic [2:0] exp_cmd);
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(cmd_valid), 32'(exp_valid));
        check_eq({tag, "_cmd"}, 32'(cmd), 32'(exp_cmd));
        vsync = 1'b1;
        @(negedge clk);
        check_eq({tag, "_pulse_end"}, 32'(cmd_valid), 32'd0);
    endtask

    initial begin
        int exp_rep;
        // Reset values
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_cmd", 32'(cmd), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);

        // W press + release queues one "up"
        tap(8'h1D);
        check_eq("w_count", 32'(fifo_count), 32'd1);
        frame("w_issue", 1'b1, 3'd1);
        check_eq("w_count_after", 32'(fifo_count), 32'd0);
        frame("empty_frame", 1'b0, 3'd1);

        // Extended right arrow press + release
        send_byte(8'hE0);
        send_byte(8'h74);
        check_eq("ext_make_count", 32'(fifo_count), 32'd1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
        check_eq("ext_brk_count", 32'(fifo_count), 32'd1);
        frame("ext_issue", 1'b1, 3'd4);

        // Unmapped make codes, and E0-prefixed W (unmapped when extended)
        send_byte(8'h15);
        send_byte(8'hE0);
        send_byte(8'h1D);
        check_eq("unmapped_count", 32'(fifo_count), 32'd0);

        // Typematic repeat
        send_byte(8'h21);
        send_byte(8'h21);
        send_byte(8'h21);
        send_byte(8'hF0);
        send_byte(8'h21);
        send_byte(8'h21);
`ifdef REPEAT_SUPPRESS_EN
        exp_rep = 2;
`else
        exp_rep = 4;
`endif
        check_eq("repeat_count", 32'(fifo_count), 32'(exp_rep));
        for (int i = 0; i < exp_rep; i++) frame("repeat_issue", 1'b1, 3'd5);
        check_eq("repeat_drained", 32'(fifo_count), 32'd0);

        // Overflow: six keys into a four-entry FIFO
        do_reset();
        tap(8'h1D);
        tap(8'h1B);
        tap(8'h1C);
        tap(8'h23);
        check_eq("full_no_ovf", 32'(overflow), 32'd0);
        tap(8'h21);
        tap(8'h22);
        check_eq("ovf_count", 32'(fifo_count), 32'd4);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        frame("ovf_issue0", 1'b1, 3'd1);
        frame("ovf_issue1", 1'b1, 3'd2);
        frame("ovf_issue2", 1'b1, 3'd3);
        frame("ovf_issue3", 1'b1, 3'd4);
        frame("ovf_empty", 1'b0, 3'd4);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop on the same cycle with a full FIFO
        do_reset();
        tap(8'h1D);
        tap(8'h1B);
        tap(8'h1C);
        tap(8'h23);
        check_eq("pp_full", 32'(fifo_count), 32'd4);
        @(negedge clk);
        flag     = 1'b1;
        scancode = 8'h32;
        vsync    = 1'b0;
        @(negedge clk);
        flag = 1'b0;
        check_eq("pp_valid", 32'(cmd_valid), 32'd1);
        check_eq("pp_cmd", 32'(cmd), 32'd1);
        check_eq("pp_count", 32'(fifo_count), 32'd4);
        check_eq("pp_ovf", 32'(overflow), 32'd0);
        vsync = 1'b1;
        frame("pp_issue1", 1'b1, 3'd2);
        frame("pp_issue2", 1'b1, 3'd3);
        frame("pp_issue3", 1'b1, 3'd4);
        frame("pp_issue4", 1'b1, 3'd7);

        // Reset mid-sequence after E0, with an entry queued
        send_byte(8'h1B);
        send_byte(8'hE0);
        do_reset();
        check_eq("mid_rst_valid", 32'(cmd_valid), 32'd0);
        check_eq("mid_rst_cmd", 32'(cmd), 32'd0);
        check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
        check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
        send_byte(8'h1C);
        check_eq("post_rst_count", 32'(fifo_count), 32'd1);
        frame("post_rst_issue", 1'b1, 3'd3);

        // Reset wins over a simultaneous strobe
        @(negedge clk);
        reset    = 1'b1;
        flag     = 1'b1;
        scancode = 8'h1D;
        @(negedge clk);
        reset = 1'b0;
        flag  = 1'b0;
        check_eq("rst_prio_count", 32'(fifo_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
